// File: rtl/i3c_data_shifter.sv
// Bit-level data shifter for I3C SDR / I2C data phases: DATA_WIDTH bits MSB first plus a ninth bit per word.
// Define I3C_PARITY_EN for the I3C T-bit (odd parity) ninth bit; leave it undefined for I2C ACK/NACK.
module i3c_data_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 16,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  is_read_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  bit_tick_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic [LEN_W-1:0]      word_cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    NINTH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int              BIT_W    = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic                    is_read_q;
  logic [LEN_W-1:0]        len_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [BIT_W-1:0]        bit_cnt_q;

  logic accept_start, load_word, read_begin, shift_bit, ninth_end, ninth_err;
  logic last_word, release_sda;

  // Handshake: a word moves on a cycle where tx_valid_i and tx_ready_o are both high. tx_ready_o never
  // depends on tx_valid_i; it is high only in LOAD of a write with no abort, and tx_data_i must be stable then.
  assign tx_ready_o = (state_q == LOAD) && !is_read_q && !abort_i;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign state_o    = state_q;
  assign last_word  = (word_cnt_o + LEN_W'(1)) == len_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    load_word    = 1'b0;
    read_begin   = 1'b0;
    shift_bit    = 1'b0;
    ninth_end    = 1'b0;
    ninth_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept_start = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (is_read_q) begin
          read_begin = 1'b1;
          state_d    = SHIFT;
        end else if (tx_valid_i) begin
          load_word = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (bit_tick_i) begin
          shift_bit = 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = NINTH;
        end
      end
      NINTH: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (bit_tick_i) begin
          ninth_end = 1'b1;
`ifdef I3C_PARITY_EN
          ninth_err = is_read_q && (sda_i != ~^shreg_q);
`else
          ninth_err = !is_read_q && sda_i;
`endif
          state_d = (last_word || ninth_err) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign release_sda = (state_d == DONE) || ((state_d == IDLE) && (state_q != IDLE));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_o      <= 1'b1;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      word_cnt_o <= '0;
      error_o    <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      is_read_q  <= 1'b0;
      len_q      <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      if (accept_start) begin
        is_read_q  <= is_read_i;
        len_q      <= (len_i == '0) ? LEN_W'(1) : len_i;
        word_cnt_o <= '0;
        error_o    <= 1'b0;
      end
      if (load_word) begin
        shreg_q   <= tx_data_i;
        bit_cnt_q <= '0;
        sda_o     <= tx_data_i[DATA_WIDTH-1];
        sda_oe_o  <= 1'b1;
      end
      if (read_begin) begin
        shreg_q   <= '0;
        bit_cnt_q <= '0;
        sda_o     <= 1'b1;
        sda_oe_o  <= 1'b0;
      end
      if (shift_bit) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        if (is_read_q) begin
          shreg_q <= {shreg_q[DATA_WIDTH-2:0], sda_i};
        end else begin
          // Rotate rather than shift so the word's parity is still available for the T-bit.
          shreg_q <= {shreg_q[DATA_WIDTH-2:0], shreg_q[DATA_WIDTH-1]};
          sda_o   <= shreg_q[DATA_WIDTH-2];
        end
        if (bit_cnt_q == LAST_BIT) begin
`ifdef I3C_PARITY_EN
          sda_o    <= is_read_q ? 1'b1 : ~^shreg_q;
          sda_oe_o <= !is_read_q;
`else
          sda_o    <= is_read_q ? last_word : 1'b1;
          sda_oe_o <= is_read_q;
`endif
        end
      end
      if (ninth_end) begin
        word_cnt_o <= word_cnt_o + LEN_W'(1);
        if (is_read_q) begin
          rx_data_o  <= shreg_q;
          rx_valid_o <= 1'b1;
          sda_o      <= 1'b1;
          sda_oe_o   <= 1'b0;
        end
        if (ninth_err) error_o <= 1'b1;
      end
      if (release_sda) begin
        sda_o    <= 1'b1;
        sda_oe_o <= 1'b0;
      end
    end
  end

endmodule
